param_fifo: RTL and testbench

PARAM_FIFO -- requirements
Module: param_fifo

---
 rtl/fifo_pkg.sv | 8 +
 rtl/fifo_ram.sv | 19 +
 rtl/param_fifo.sv | 65 ++++++
 tb/tb_param_fifo.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: default FIFO width/depth constants and the pointer-width helper shared by param_fifo and fifo_ram
package fifo_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 1024;
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x WIDTH storage, unreset; ports clk, we/waddr/wdata (synchronous write), raddr/rdata (asynchronous read)
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/param_fifo.sv
// param_fifo: show-ahead sync FIFO (clk, rstn sync active-low; push/indata/full/almost_full; pop/outdata/empty; count), sticky overflow/underflow ports only with PARAM_FIFO_ERRFLAG_EN
module param_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_LVL = DEPTH - 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [WIDTH-1:0]       indata,
  input  logic                   push,
  output logic                   full,
  output logic                   almost_full,
  output logic [WIDTH-1:0]       outdata,
  input  logic                   pop,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
`ifdef PARAM_FIFO_ERRFLAG_EN
  ,
  output logic                   overflow,
  output logic                   underflow
`endif
);
  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] AFL = PW'(AFULL_LVL);
  logic [PW-1:0] head, tail;
  logic [WIDTH-1:0] rdata;
  logic wr, rd;
  assign empty = head == tail;
  assign full = head == {~tail[PW-1], tail[AW-1:0]};
  assign wr = push & (~full | pop);
  assign rd = pop & ~empty;
  assign almost_full = count >= AFL;
  assign outdata = empty ? '0 : rdata;
  always_ff @(posedge clk)
    if (!rstn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(rd);
      tail  <= tail + PW'(wr);
      count <= (wr & ~rd) ? count + PW'(1) : (rd & ~wr) ? count - PW'(1) : count;
    end
`ifdef PARAM_FIFO_ERRFLAG_EN
  always_ff @(posedge clk)
    if (!rstn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow | (push & full & ~pop);
      underflow <= underflow | (pop & empty & ~push);
    end
`endif
  fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (wr),
    .waddr (tail[AW-1:0]),
    .wdata (indata),
    .raddr (head[AW-1:0]),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: directed checks of param_fifo at DEPTH=4 (AFULL_LVL=3) and DEPTH=8 (AFULL_LVL=6) sharing one stimulus
module tb_param_fifo;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic push = 1'b0;
  logic pop = 1'b0;
  logic [7:0] din = '0;
  logic full4, af4, empty4, ov4, uf4;
  logic [7:0] out4;
  logic [2:0] cnt4;
  logic full8, af8, empty8, ov8, uf8;
  logic [7:0] out8;
  logic [3:0] cnt8;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
`ifndef PARAM_FIFO_ERRFLAG_EN
  assign ov4 = 1'b0;
  assign uf4 = 1'b0;
  assign ov8 = 1'b0;
  assign uf8 = 1'b0;
`endif
  param_fifo #(.WIDTH(8), .DEPTH(4), .AFULL_LVL(3)) u4 (
    .clk(clk), .rstn(rstn), .indata(din), .push(push), .full(full4), .almost_full(af4),
    .outdata(out4), .pop(pop), .empty(empty4), .count(cnt4)
`ifdef PARAM_FIFO_ERRFLAG_EN
    , .overflow(ov4), .underflow(uf4)
`endif
  );
  param_fifo #(.WIDTH(8), .DEPTH(8), .AFULL_LVL(6)) u8 (
    .clk(clk), .rstn(rstn), .indata(din), .push(push), .full(full8), .almost_full(af8),
    .outdata(out8), .pop(pop), .empty(empty8), .count(cnt8)
`ifdef PARAM_FIFO_ERRFLAG_EN
    , .overflow(ov8), .underflow(uf8)
`endif
  );
  task automatic do_reset();
    rstn = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask
  task automatic cyc(input logic p, input logic q, input logic [7:0] d);
    push = p;
    pop = q;
    din = d;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    checks++; if (empty4 !== 1'b1) begin errors++; $display("FAIL reset_empty4 got %b exp 1", empty4); end
    checks++; if (full4 !== 1'b0) begin errors++; $display("FAIL reset_full4 got %b exp 0", full4); end
    checks++; if (af4 !== 1'b0) begin errors++; $display("FAIL reset_af4 got %b exp 0", af4); end
    checks++; if (cnt4 !== 3'd0) begin errors++; $display("FAIL reset_cnt4 got %0d exp 0", cnt4); end
    checks++; if (out4 !== 8'h00) begin errors++; $display("FAIL reset_out4 got %h exp 00", out4); end
    checks++; if (empty8 !== 1'b1) begin errors++; $display("FAIL reset_empty8 got %b exp 1", empty8); end
    checks++; if (out8 !== 8'h00) begin errors++; $display("FAIL reset_out8 got %h exp 00", out8); end
  endtask
  task automatic test_basic();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h11;
    exp_d[1] = 8'h22;
    exp_d[2] = 8'h33;
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, exp_d[i]);
    checks++; if (cnt8 !== 4'd3) begin errors++; $display("FAIL basic_count got %0d exp 3", cnt8); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (out8 !== exp_d[i]) begin errors++; $display("FAIL basic_pop%0d got %h exp %h", i, out8, exp_d[i]); end
      cyc(1'b0, 1'b1, 8'h00);
    end
    checks++; if (empty8 !== 1'b1) begin errors++; $display("FAIL basic_empty got %b exp 1", empty8); end
    checks++; if (out8 !== 8'h00) begin errors++; $display("FAIL basic_out_zero got %h exp 00", out8); end
  endtask
  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 8'hA0 + 8'(i));
      if (i == 1) begin
        checks++; if (af4 !== 1'b0) begin errors++; $display("FAIL ovf_af_at2 got %b exp 0", af4); end
      end
      if (i == 2) begin
        checks++; if (af4 !== 1'b1) begin errors++; $display("FAIL ovf_af_at3 got %b exp 1", af4); end
        checks++; if (full4 !== 1'b0) begin errors++; $display("FAIL ovf_full_at3 got %b exp 0", full4); end
      end
    end
    checks++; if (full4 !== 1'b1) begin errors++; $display("FAIL ovf_full_at4 got %b exp 1", full4); end
    cyc(1'b1, 1'b0, 8'hA4);
    checks++; if (cnt4 !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d exp 4", cnt4); end
`ifdef PARAM_FIFO_ERRFLAG_EN
    checks++; if (ov4 !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", ov4); end
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL ovf_flag8 got %b exp 0", ov8); end
`endif
    for (int i = 0; i < 4; i++) begin
      checks++; if (out4 !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL ovf_drain%0d got %h exp %h", i, out4, 8'hA0 + 8'(i)); end
      cyc(1'b0, 1'b1, 8'h00);
    end
    checks++; if (empty4 !== 1'b1) begin errors++; $display("FAIL ovf_empty got %b exp 1", empty4); end
  endtask
  task automatic test_full_push_pop();
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h11;
    exp_d[1] = 8'h12;
    exp_d[2] = 8'h13;
    exp_d[3] = 8'hB0;
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'h10 + 8'(i));
    cyc(1'b1, 1'b1, 8'hB0);
    checks++; if (cnt4 !== 3'd4) begin errors++; $display("FAIL fpp_count got %0d exp 4", cnt4); end
    checks++; if (full4 !== 1'b1) begin errors++; $display("FAIL fpp_full got %b exp 1", full4); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out4 !== exp_d[i]) begin errors++; $display("FAIL fpp_drain%0d got %h exp %h", i, out4, exp_d[i]); end
      cyc(1'b0, 1'b1, 8'h00);
    end
`ifdef PARAM_FIFO_ERRFLAG_EN
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL fpp_ovf got %b exp 0", ov4); end
`endif
  endtask
  task automatic test_empty_push_pop();
    do_reset();
    cyc(1'b1, 1'b1, 8'hC5);
    checks++; if (cnt4 !== 3'd1) begin errors++; $display("FAIL epp_count got %0d exp 1", cnt4); end
    checks++; if (out4 !== 8'hC5) begin errors++; $display("FAIL epp_out got %h exp c5", out4); end
`ifdef PARAM_FIFO_ERRFLAG_EN
    checks++; if (uf4 !== 1'b0) begin errors++; $display("FAIL epp_uf got %b exp 0", uf4); end
`endif
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 8'h00);
    checks++; if (cnt4 !== 3'd0) begin errors++; $display("FAIL epp_underpop_count got %0d exp 0", cnt4); end
`ifdef PARAM_FIFO_ERRFLAG_EN
    checks++; if (uf4 !== 1'b1) begin errors++; $display("FAIL epp_uf_set got %b exp 1", uf4); end
`endif
  endtask
  task automatic test_wrap();
    logic [7:0] q [$];
    logic p, r, wr, rd;
    logic [7:0] exp_out;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      p = (i < 6) || (i >= 7 && i <= 13);
      r = (i >= 6 && i <= 12) || (i >= 14);
      wr = p && (q.size() < 8 || r);
      rd = r && q.size() > 0;
      if (rd) void'(q.pop_front());
      if (wr) q.push_back(8'h40 + 8'(i));
      cyc(p, r, 8'h40 + 8'(i));
      exp_out = q.size() > 0 ? q[0] : 8'h00;
      checks++; if (cnt8 !== 4'(q.size())) begin errors++; $display("FAIL wrap_count%0d got %0d exp %0d", i, cnt8, q.size()); end
      checks++; if (out8 !== exp_out) begin errors++; $display("FAIL wrap_out%0d got %h exp %h", i, out8, exp_out); end
      checks++; if (af8 !== (q.size() >= 6)) begin errors++; $display("FAIL wrap_af%0d got %b exp %b", i, af8, q.size() >= 6); end
    end
    checks++; if (empty8 !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b exp 1", empty8); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'h20 + 8'(i));
    checks++; if (cnt8 !== 4'd5) begin errors++; $display("FAIL rmid_pre_count got %0d exp 5", cnt8); end
    rstn = 1'b0;
    push = 1'b1;
    din = 8'h77;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    push = 1'b0;
    checks++; if (cnt8 !== 4'd0) begin errors++; $display("FAIL rmid_count got %0d exp 0", cnt8); end
    checks++; if (empty8 !== 1'b1) begin errors++; $display("FAIL rmid_empty got %b exp 1", empty8); end
    checks++; if (out8 !== 8'h00) begin errors++; $display("FAIL rmid_out got %h exp 00", out8); end
    checks++; if (cnt4 !== 3'd0) begin errors++; $display("FAIL rmid_count4 got %0d exp 0", cnt4); end
    checks++; if (full4 !== 1'b0) begin errors++; $display("FAIL rmid_full4 got %b exp 0", full4); end
`ifdef PARAM_FIFO_ERRFLAG_EN
    checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL rmid_ovf got %b exp 0", ov4); end
    checks++; if (uf4 !== 1'b0) begin errors++; $display("FAIL rmid_uf got %b exp 0", uf4); end
`endif
    cyc(1'b0, 1'b0, 8'h00);
    checks++; if (empty8 !== 1'b1) begin errors++; $display("FAIL rmid_idle_empty got %b exp 1", empty8); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
